// File: rtl/freq_pkg.sv
// Shared constants and helpers for the BCD frequency counter.
package freq_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned DEF_CLK_HZ = 50_000_000;
  localparam int unsigned DEF_DIGITS = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  // Gate counter width; never narrower than one bit.
  function automatic int unsigned gate_cnt_w(input int unsigned gate_cycles);
    return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One 0..9 BCD decade with synchronous clear; exposes its pre-clear next value
// so the parent can latch the post-increment count in the clearing cycle.
module bcd_decade
  import freq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output bcd_t q_o,
  output bcd_t nxt_o,
  output logic carry_o
);

  bcd_t q_q, q_d, nxt;

  always_comb begin
    nxt = q_q;
    if (inc_i) begin
      nxt = (q_q == BCD_W'(9)) ? '0 : q_q + BCD_W'(1);
    end
    q_d = clr_i ? '0 : nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign nxt_o   = nxt;
  // High when the next increment would roll this decade over.
  assign carry_o = (q_q == BCD_W'(9));

endmodule

// File: rtl/freq_counter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// fixed gate and latches the result as saturating BCD with an overflow flag.
module freq_counter
  import freq_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
  parameter int unsigned GATE_CYCLES = CLK_HZ,
  parameter int unsigned DIGITS      = DEF_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sig_in,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                    overflow,
  output logic                    valid
);

  localparam int unsigned     GateW    = gate_cnt_w(GATE_CYCLES);
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);

  logic [2:0]              sync_q, sync_d;
  logic [1:0]              arm_q, arm_d;
  logic [GateW-1:0]        gate_q, gate_d;
  logic                    ovf_q, ovf_d;
  logic [BCD_W*DIGITS-1:0] bcd_out_q, bcd_out_d;
  logic                    overflow_q, overflow_d;
  logic                    valid_q, valid_d;
  logic [BCD_W*DIGITS-1:0] acc_q, acc_nxt;
  logic [DIGITS-1:0]       inc;
  logic [DIGITS-1:0]       at_nine;
  logic                    armed, rise, cnt_edge, terminal, acc_clr;
  logic                    all_nine, sat_hit, ovf_post;

  always_comb begin
    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect delay.
    sync_d     = {sync_q[1:0], sig_in};
    armed      = (arm_q == 2'd3);
    arm_d      = armed ? arm_q : arm_q + 2'd1;
    rise       = sync_q[1] & ~sync_q[2];
    cnt_edge   = en & armed & rise;
    terminal   = en & (gate_q == GateLast);
    acc_clr    = ~en | terminal;
    gate_d     = acc_clr ? '0 : gate_q + GateW'(1);
    all_nine   = &at_nine;
    sat_hit    = cnt_edge & all_nine;
    ovf_post   = ovf_q | sat_hit;
    ovf_d      = acc_clr ? 1'b0 : ovf_post;
    bcd_out_d  = terminal ? acc_nxt : bcd_out_q;
    overflow_d = terminal ? ovf_post : overflow_q;
    valid_d    = terminal;
  end

  // Saturation: once every decade reads 9 the cascade stops advancing.
  assign inc[0] = cnt_edge & ~all_nine;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    if (k > 0) begin : g_chain
      assign inc[k] = inc[k-1] & at_nine[k-1];
    end

    bcd_decade u_dec (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (acc_clr),
      .inc_i   (inc[k]),
      .q_o     (acc_q[k*BCD_W +: BCD_W]),
      .nxt_o   (acc_nxt[k*BCD_W +: BCD_W]),
      .carry_o (at_nine[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      arm_q      <= '0;
      gate_q     <= '0;
      ovf_q      <= 1'b0;
      bcd_out_q  <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      arm_q      <= arm_d;
      gate_q     <= gate_d;
      ovf_q      <= ovf_d;
      bcd_out_q  <= bcd_out_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign bcd_out  = bcd_out_q;
  assign overflow = overflow_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_freq_counter.sv
// Bench for freq_counter: a 4-decade and a 1-decade instance share stimulus and
// are compared every cycle against an integer edge-count model.
module tb_freq_counter;

  localparam int unsigned GATE = 100;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        en     = 1'b0;
  logic        sig_in = 1'b0;
  logic [15:0] bcd4;
  logic [3:0]  bcd1;
  logic        ovf4, ovf1, valid4, valid1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state: pin history, cycles since reset, gate position, edge counts.
  logic [2:0]  m_hist  = '0;
  int unsigned m_since = 0;
  int unsigned m_gate  = 0;
  int unsigned m_cnt   = 0;
  int unsigned m_lat   = 0;
  logic        m_valid = 1'b0;
  logic        rise_now;

  freq_counter #(.GATE_CYCLES(GATE), .DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .bcd_out(bcd4), .overflow(ovf4), .valid(valid4)
  );

  freq_counter #(.GATE_CYCLES(GATE), .DIGITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .bcd_out(bcd1), .overflow(ovf1), .valid(valid1)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [15:0] to_bcd(input int unsigned v, input int unsigned nd);
    logic [15:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a pin rise counts 3 clocks later, never within 3 clocks of reset.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_hist = '0; m_since = 0; m_gate = 0; m_cnt = 0; m_lat = 0; m_valid = 1'b0;
    end else begin
      rise_now = (m_since >= 3) && m_hist[1] && !m_hist[2];
      m_hist   = {m_hist[1:0], sig_in};
      if (m_since < 3) m_since++;
      m_valid = 1'b0;
      if (!en) begin
        m_gate = 0;
        m_cnt  = 0;
      end else begin
        if (rise_now) m_cnt++;
        if (m_gate == GATE - 1) begin
          m_lat   = m_cnt;
          m_valid = 1'b1;
          m_cnt   = 0;
          m_gate  = 0;
        end else begin
          m_gate++;
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  initial forever begin
    @(negedge clk);
    chk("valid4", valid4, m_valid);
    chk("valid1", valid1, m_valid);
    chk("bcd4", bcd4, to_bcd((m_lat > 9999) ? 9999 : m_lat, 4));
    chk("bcd1", bcd1, to_bcd((m_lat > 9) ? 9 : m_lat, 1));
    chk("ovf4", ovf4, m_lat > 9999);
    chk("ovf1", ovf1, m_lat > 9);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gate(input int unsigned p);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      if (m_gate == p) got = 1'b1;
    end
    chk("gate_reached", got, 1'b1);
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      step(); sig_in = 1'b1;
      step(); sig_in = 1'b0;
    end
  endtask

  // Wait for the next valid pulse (optionally toggling sig_in every clock),
  // then optionally check the latched result against hand-computed values.
  task automatic expect_valid(input logic tog, input logic check, input string nm,
                              input logic [15:0] e4, input logic eo4,
                              input logic [3:0] e1, input logic eo1,
                              output int t_seen);
    logic got;
    got    = 1'b0;
    t_seen = 0;
    for (int i = 0; i < 250 && !got; i++) begin
      step();
      if (tog) sig_in = ~sig_in;
      @(negedge clk);
      if (valid4) begin
        got    = 1'b1;
        t_seen = cyc;
      end
    end
    chk({nm, "_valid_seen"}, got, 1'b1);
    if (check && got) begin
      chk({nm, "_bcd4"}, bcd4, e4);
      chk({nm, "_ovf4"}, ovf4, eo4);
      chk({nm, "_bcd1"}, bcd1, e1);
      chk({nm, "_ovf1"}, ovf1, eo1);
    end
  endtask

  task automatic check_cleared(input string nm);
    @(negedge clk);
    chk({nm, "_bcd4"}, bcd4, 16'h0000);
    chk({nm, "_bcd1"}, bcd1, 4'h0);
    chk({nm, "_ovf1"}, ovf1, 1'b0);
    chk({nm, "_valid"}, valid4, 1'b0);
  endtask

  initial begin
    int t_prev, t_now, t_en;

    repeat (3) step();
    check_cleared("reset");
    rst = 1'b0;
    en  = 1'b1;

    // 37 edges in one gate.
    wait_gate(5);
    pulse(37);
    expect_valid(1'b0, 1'b1, "g37", 16'h0037, 1'b0, 4'h9, 1'b1, t_prev);

    // Toggle every clock: one partial gate, then three full gates of 50 edges.
    expect_valid(1'b1, 1'b0, "tog_partial", '0, 1'b0, '0, 1'b0, t_now);
    chk("tog_gap0", t_now - t_prev, GATE);
    t_prev = t_now;
    for (int g = 0; g < 3; g++) begin
      expect_valid(1'b1, 1'b1, "tog50", 16'h0050, 1'b0, 4'h9, 1'b1, t_now);
      chk("tog_gap", t_now - t_prev, GATE);
      t_prev = t_now;
    end
    sig_in = 1'b0;
    expect_valid(1'b0, 1'b0, "flush", '0, 1'b0, '0, 1'b0, t_now);

    // 12 edges overflow the single decade; 3 edges clear it again.
    wait_gate(10);
    pulse(12);
    expect_valid(1'b0, 1'b1, "g12", 16'h0012, 1'b0, 4'h9, 1'b1, t_now);
    wait_gate(10);
    pulse(3);
    expect_valid(1'b0, 1'b1, "g3", 16'h0003, 1'b0, 4'h3, 1'b0, t_now);

    // Reset at gate cycle 50 after 20 edges.
    wait_gate(10);
    pulse(20);
    wait_gate(52);
    rst = 1'b1;
    check_cleared("mid_rst");
    step();
    rst = 1'b0;
    wait_gate(10);
    pulse(5);
    expect_valid(1'b0, 1'b1, "g5", 16'h0005, 1'b0, 4'h5, 1'b0, t_now);

    // sig_in high through reset and afterwards.
    step();
    sig_in = 1'b1;
    rst    = 1'b1;
    check_cleared("hi_rst");
    repeat (2) step();
    rst = 1'b0;
    expect_valid(1'b0, 1'b1, "hi_hold", 16'h0000, 1'b0, 4'h0, 1'b0, t_now);
    sig_in = 1'b0;

    // en dropped at gate cycle 40 for 30 cycles.
    wait_gate(10);
    pulse(8);
    expect_valid(1'b0, 1'b1, "g8", 16'h0008, 1'b0, 4'h8, 1'b0, t_now);
    wait_gate(10);
    pulse(3);
    wait_gate(40);
    en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("en_off_valid", valid4, 1'b0);
      chk("en_off_bcd4", bcd4, 16'h0008);
      step();
    end
    en   = 1'b1;
    t_en = cyc;
    wait_gate(10);
    pulse(3);
    expect_valid(1'b0, 1'b1, "en_back", 16'h0003, 1'b0, 4'h3, 1'b0, t_now);
    chk("en_back_gap", t_now - t_en, GATE);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/freq_counter.md
FREQ_COUNTER -- requirements
Module: freq_counter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, giving the system clock frequency in Hz.
REQ-002 The block SHALL have parameter GATE_CYCLES, default CLK_HZ, giving the gate length in clock cycles (1 s at default).
REQ-003 The block SHALL have parameter DIGITS, default 4, giving the number of BCD decades.
REQ-004 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-005 The block SHALL have these ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  measurement enable.
- sig_in  in  1  asynchronous signal under measurement.
- bcd_out  out  4*DIGITS  latched count; nibble k is decade k (nibble 0 = units); each nibble drives one 7-segment decoder.
- overflow  out  1  latched result exceeded the DIGITS-decade maximum.
- valid  out  1  one-cycle pulse when bcd_out/overflow update.

Function
REQ-006 sig_in SHALL pass through a 2-flop synchronizer followed by a third flop for rising-edge detection; an edge SHALL be registered 3 clk cycles after the pin transition.
REQ-007 After reset release, edge detection SHALL stay disarmed for 3 cycles so that a sig_in held high through reset produces no count.
REQ-008 The gate counter SHALL run 0..GATE_CYCLES-1 while en=1 and wrap to 0 after the terminal count.
REQ-009 The BCD accumulator SHALL be a cascade of DIGITS decade counters, each 0..9, where decade k+1 increments only when decades 0..k are all 9 and an edge occurs.
REQ-010 Edges detected in gate cycles 0..GATE_CYCLES-1 SHALL be counted, including an edge in the terminal cycle.
REQ-011 At the terminal cycle, the block SHALL, in the same clock:
- latch the post-increment accumulator into bcd_out;
- latch the overflow state into overflow;
- pulse valid for exactly 1 cycle;
- clear the accumulator and the overflow state to 0.
REQ-012 An edge arriving while the accumulator holds all 9s SHALL saturate the accumulator at all 9s and set the internal overflow state; further edges SHALL be ignored until the next clear.
REQ-013 When en=0, the gate counter, accumulator and internal overflow state SHALL be held at 0, and bcd_out/overflow SHALL hold their last latched values with valid=0.
REQ-014 When en rises, a new gate SHALL start at gate count 0 on the next cycle; a partial gate SHALL never produce a valid pulse.
REQ-015 bcd_out nibbles SHALL never hold values 10..15.

Reset
REQ-016 Asserting rst SHALL immediately clear bcd_out, overflow, valid, the gate counter, the accumulator, the synchronizer flops and the arm counter.
REQ-017 Reset asserted mid-gate SHALL discard the partial measurement, with no valid pulse.

Structure
REQ-018 A shared package freq_pkg SHALL hold the BCD_W=4 nibble width, the default CLK_HZ and DIGITS constants, and the width function for the gate counter (clog2 of GATE_CYCLES).
REQ-019 One sub-module, bcd_decade, SHALL implement a single 0..9 decade with clr, inc and carry-out signals, instantiated DIGITS times via generate.
REQ-020 The edge synchronizer SHALL be inline; no further hierarchy.

Verification (bench uses GATE_CYCLES=100, DIGITS=4)
REQ-021 37 sig_in rising edges spread inside one gate -> valid pulse at gate cycle 99, bcd_out=16'h0037, overflow=0.
REQ-022 sig_in toggling every clock (50 edges per gate) for 3 gates -> three valid pulses exactly 100 cycles apart, each with bcd_out=16'h0050.
REQ-023 DIGITS=1 build, 12 edges in one gate -> bcd_out=4'h9, overflow=1; next gate with 3 edges -> bcd_out=4'h3, overflow=0.
REQ-024 sig_in high through reset and held high afterwards -> first latched result bcd_out=0.
REQ-025 rst pulsed at gate cycle 50 after 20 edges -> outputs 0 immediately and no valid pulse; next full gate with 5 edges -> bcd_out=16'h0005.
REQ-026 en dropped at gate cycle 40 and raised 30 cycles later -> no valid pulse and bcd_out held while en=0; next valid pulse 100 cycles after en rises.
